// File: rtl/codificador_pkg.sv
// codificador_pkg: shared widths and FSM state type for the serial priority encoder
package codificador_pkg;
    localparam int N = 8;
    localparam int W = 3;
    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;
endpackage

// File: rtl/codificador_prioridad.sv
// codificador_prioridad: combinational highest-set-bit index with any-set flag
module codificador_prioridad #(
    parameter int N = codificador_pkg::N,
    parameter int W = codificador_pkg::W
) (
    input  logic [N-1:0] d_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    // ascending scan so the last hit, the highest set bit, wins
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++)
            if (d_i[i]) idx_o = W'(i);
    end
    assign any_o = |d_i;
endmodule

// File: rtl/codificador_serie.sv
// codificador_serie: emits the indices of a latched request vector one per handshake, highest first
module codificador_serie #(
    parameter int N = codificador_pkg::N,
    parameter int W = codificador_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] D,
    input  logic         en,
    output logic [W-1:0] Q,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic         done
);
    import codificador_pkg::*;
    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [W-1:0]   idx;
    logic           any;
    codificador_prioridad #(.N(N), .W(W)) u_prio (
        .d_i   (pend_q),
        .idx_o (idx),
        .any_o (any)
    );
    assign valid = (state_q == EMIT) && any;
    assign Q     = valid ? idx : '0;
    assign busy  = state_q != IDLE;
    assign done  = state_q == FIN;
    // latch in IDLE, retire one bit per accepted code in EMIT, single done cycle in FIN
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        if (state_q == IDLE && en) begin
            pend_d  = D;
            state_d = |D ? EMIT : FIN;
        end else if (state_q == EMIT && ready) begin
            pend_d  = pend_q & ~({{(N-1){1'b0}}, 1'b1} << idx);
            state_d = |pend_d ? EMIT : FIN;
        end else if (state_q == FIN) begin
            state_d = IDLE;
        end
    end
    // state and pending vector registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_codificador_serie.sv
// tb_codificador_serie: directed table and sequence checks for codificador_serie
module tb_codificador_serie;
    logic       clk = 0, rst = 1, en = 0, ready = 0;
    logic [7:0] D = '0;
    logic [2:0] Q;
    logic       valid, busy, done;
    int vecs = 0, errs = 0;

    typedef struct { logic [7:0] d; int q; } vec_t;
    vec_t tbl [8];

    codificador_serie dut (
        .clk(clk), .rst(rst), .D(D), .en(en), .Q(Q),
        .valid(valid), .ready(ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int q, input int v, input int b, input int dn);
        chk({name, ".Q"}, int'(Q), q);
        chk({name, ".valid"}, int'(valid), v);
        chk({name, ".busy"}, int'(busy), b);
        chk({name, ".done"}, int'(done), dn);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i].d = 8'b1 << i;
            tbl[i].q = i;
        end
        #2;
        chk_out("reset", 0, 0, 0, 0);
        tick;
        rst = 0;
        tick;
        chk_out("idle_after_reset", 0, 0, 0, 0);

        // one-hot table: each vector yields exactly its bit index
        ready = 1;
        for (int i = 0; i < 8; i++) begin
            D = tbl[i].d; en = 1;
            tick;
            en = 0;
            chk_out($sformatf("onehot%0d.emit", i), tbl[i].q, 1, 1, 0);
            tick;
            chk_out($sformatf("onehot%0d.fin", i), 0, 0, 1, 1);
            tick;
            chk_out($sformatf("onehot%0d.idle", i), 0, 0, 0, 0);
        end

        // 1010_0100 -> 7, 5, 2, done, idle
        D = 8'b1010_0100; en = 1;
        tick;
        en = 0;
        chk_out("a4.c7", 7, 1, 1, 0);
        tick;
        chk_out("a4.c5", 5, 1, 1, 0);
        tick;
        chk_out("a4.c2", 2, 1, 1, 0);
        tick;
        chk_out("a4.fin", 0, 0, 1, 1);
        tick;
        chk_out("a4.idle", 0, 0, 0, 0);

        // backpressure: code held while ready=0, accepted once
        ready = 0; D = 8'h01; en = 1;
        tick;
        en = 0;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("hold%0d", i), 0, 1, 1, 0);
            tick;
        end
        ready = 1;
        chk_out("hold3", 0, 1, 1, 0);
        tick;
        chk_out("hold.fin", 0, 0, 1, 1);
        tick;
        chk_out("hold.idle", 0, 0, 0, 0);

        // all-zero vector: no valid, done next cycle
        D = 8'h00; en = 1;
        tick;
        en = 0;
        chk_out("zero.fin", 0, 0, 1, 1);
        tick;
        chk_out("zero.idle", 0, 0, 0, 0);

        // FF then an ignored load while busy
        D = 8'hFF; en = 1;
        tick;
        D = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            chk_out($sformatf("ff.c%0d", i), i, 1, 1, 0);
            tick;
        end
        en = 0;
        chk_out("ff.fin", 0, 0, 1, 1);
        tick;
        chk_out("ff.idle", 0, 0, 0, 0);
        tick;
        chk_out("ff.no_relatch", 0, 0, 0, 0);

        // asynchronous reset mid-vector discards the rest
        D = 8'b1100_0000; en = 1;
        tick;
        en = 0;
        chk_out("rst.c7", 7, 1, 1, 0);
        tick;
        chk_out("rst.c6", 6, 1, 1, 0);
        #2 rst = 1;
        #1;
        chk_out("rst.async", 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 0;
        chk_out("rst.held", 0, 0, 0, 0);
        tick;
        chk_out("rst.no_done", 0, 0, 0, 0);
        D = 8'b0001_0000; en = 1;
        tick;
        en = 0;
        chk_out("post.c4", 4, 1, 1, 0);
        tick;
        chk_out("post.fin", 0, 0, 1, 1);
        tick;
        chk_out("post.idle", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
